arb_mux_n: RTL and testbench

Parametrised N-channel registered arbitrating multiplexer, the successor to the fixed 8:1 combinational mux.
- Channel count is set by the address width; data width is a parameter.
- Each channel presents data under a valid/ready handshake. The block arbitrates among requesting channels and registers the winner into a single output stage, with its own valid/ready handshake.
- Arbitration mode is selectable at run time: round-robin or fixed priority.
- Sits between multiple producers (register-file read ports, functional-unit result buses) and a single consumer.

---
 rtl/arb_mux_pkg.sv | 20 ++
 rtl/arb_mux_n_if.sv | 28 ++
 rtl/rr_pick_n.sv | 37 +++
 rtl/arb_mux_n.sv | 87 ++++++++
 tb/tb_arb_mux_n.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the N-channel arbitrating mux.
// Mode encoding, output-stage state and the pointer increment.
package arb_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  function automatic int unsigned next_ptr(
    input int unsigned idx,
    input int unsigned m
  );
    return (idx + 1 >= m) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_mux_n_if.sv
// Producer/consumer bundle of the arbitrating mux.
// slave is the mux side, master the environment side.
interface arb_mux_n_if #(
  parameter int n       = 4,
  parameter int address = 3
);
  localparam int m = 2 ** address;

  logic [n-1:0]       data_i [0:m-1];
  logic [m-1:0]       valid_i;
  logic [m-1:0]       ready_o;
  logic               mode_i;
  logic [n-1:0]       data_o;
  logic               valid_o;
  logic               ready_i;
  logic [address-1:0] grant_o;

  modport slave (
    input  data_i, valid_i, mode_i, ready_i,
    output ready_o, data_o, valid_o, grant_o
  );

  modport master (
    output data_i, valid_i, mode_i, ready_i,
    input  ready_o, data_o, valid_o, grant_o
  );

endinterface

// File: rtl/rr_pick_n.sv
// Combinational picker: first requester scanning up from a start
// index with wrap; fixed mode forces the start to channel 0.
module rr_pick_n
  import arb_mux_pkg::*;
#(
  parameter int address = 3
) (
  input  logic [2**address-1:0] req_i,
  input  logic [address-1:0]    start_i,
  input  logic                  mode_i,
  output logic [address-1:0]    win_o,
  output logic                  any_o
);
  localparam int m = 2 ** address;

  logic [address-1:0] start;
  logic [address-1:0] idx;
  logic               found;

  assign start = (mode_i == MODE_FIXED) ? '0 : start_i;
  assign any_o = |req_i;

  // idx wraps for free because m is a power of two
  always_comb begin
    win_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < m; i++) begin
      idx = start + address'(i);
      if (!found && req_i[idx]) begin
        win_o = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel registered arbitrating mux, round-robin or fixed
// priority, with a single valid/ready output register.
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter int n       = 4,
  parameter int address = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  arb_mux_n_if.slave  bus
);
  localparam int m = 2 ** address;

  state_t             state_q, state_d;
  logic [n-1:0]       data_q, data_d;
  logic [address-1:0] grant_q, grant_d;
  logic [address-1:0] ptr_q, ptr_d;

  logic               load;
  logic               any;
  logic               xfer;
  logic [address-1:0] win;

  rr_pick_n #(
    .address (address)
  ) u_pick (
    .req_i   (bus.valid_i),
    .start_i (ptr_q),
    .mode_i  (bus.mode_i),
    .win_o   (win),
    .any_o   (any)
  );

  assign load = (state_q == S_EMPTY) || bus.ready_i;
  assign xfer = load && any;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (any) state_d = S_FULL;
      S_FULL:  if (bus.ready_i && !any) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    bus.valid_o = (state_q == S_FULL);
    bus.data_o  = data_q;
    bus.grant_o = grant_q;
    bus.ready_o = '0;
    if (xfer && rst_ni) bus.ready_o[win] = 1'b1;
  end

  // ptr moves on every transfer so a later RR switch stays fair
  always_comb begin
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      data_d  = bus.data_i[win];
      grant_d = win;
      ptr_d   = address'(next_ptr(int'(win), m));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_arb_mux_n.sv
// Scoreboard bench for arb_mux_n: directed scenarios then random
// traffic against a behavioural arbitration model.
module tb_arb_mux_n;
  localparam int N  = 4;
  localparam int A  = 3;
  localparam int M  = 8;

  typedef struct {
    logic [N-1:0] data;
    int           grant;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  item_t exp_q[$];
  int    mptr = 0;
  bit    mfull = 0;
  logic [N-1:0] last_data = '0;
  int    last_grant = 0;

  arb_mux_n_if #(.n(N), .address(A)) bus();

  arb_mux_n #(.n(N), .address(A)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic int pick(input logic [M-1:0] v, input bit md);
    int start = md ? 0 : mptr;
    for (int i = 0; i < M; i++)
      if (v[(start + i) % M]) return (start + i) % M;
    return -1;
  endfunction

  // One clock: drive, check combinational ready, predict the edge.
  task automatic cycle(input logic [M-1:0] v, input bit md,
                       input bit rdy, input bit rnd);
    int w;
    bit load;
    logic [M-1:0] er;
    @(posedge clk);
    #1;
    bus.valid_i = v;
    bus.mode_i  = md;
    bus.ready_i = rdy;
    for (int k = 0; k < M; k++)
      bus.data_i[k] = rnd ? N'($urandom) : N'(k);
    #1;
    chk("valid_o", {31'd0, bus.valid_o}, {31'd0, mfull});
    if (!mfull) begin
      chk("hold_data", {28'd0, bus.data_o}, {28'd0, last_data});
      chk("hold_grant", {29'd0, bus.grant_o}, last_grant);
    end
    load = !mfull || rdy;
    w = pick(v, md);
    er = '0;
    if (load && w >= 0) er[w] = 1'b1;
    chk("ready_o", {24'd0, bus.ready_o}, {24'd0, er});
    if (load && w >= 0) begin
      exp_q.push_back('{data: bus.data_i[w], grant: w});
      last_data = bus.data_i[w];
      last_grant = w;
      mptr = (w + 1) % M;
      mfull = 1;
    end else if (load) begin
      mfull = 0;
    end
  endtask

  // Monitor: a held item must match the oldest prediction; pop on accept.
  always @(negedge clk) begin
    if (rst_n && bus.valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_item", 32'd1, 32'd0);
      end else begin
        chk("data_o", {28'd0, bus.data_o}, {28'd0, exp_q[0].data});
        chk("grant_o", {29'd0, bus.grant_o}, exp_q[0].grant);
        if (bus.ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.valid_i = '0;
    bus.mode_i  = 1'b0;
    bus.ready_i = 1'b0;
    for (int k = 0; k < M; k++) bus.data_i[k] = '0;
    #12;
    chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("rst_ready", {24'd0, bus.ready_o}, 32'd0);
    rst_n = 1'b1;

    // Round-robin fairness, data_i[k] = k
    repeat (9) cycle(8'hFF, 1'b0, 1'b1, 1'b0);

    // Fixed priority, channel 2 every cycle
    repeat (3) begin
      cycle(8'hA4, 1'b1, 1'b1, 1'b1);
      chk("fixed_ready", {24'd0, bus.ready_o}, 32'h04);
    end

    // Backpressure with channel 5 waiting
    cycle(8'h01, 1'b0, 1'b1, 1'b1);
    repeat (3) begin
      cycle(8'h20, 1'b0, 1'b0, 1'b1);
      chk("stall_ready", {24'd0, bus.ready_o}, 32'h00);
    end
    cycle(8'h20, 1'b0, 1'b1, 1'b1);
    chk("resume_ready", {24'd0, bus.ready_o}, 32'h20);

    // Wrap and mode switch
    cycle(8'h80, 1'b0, 1'b1, 1'b1);
    cycle(8'h48, 1'b0, 1'b1, 1'b1);
    chk("rr_3", {24'd0, bus.ready_o}, 32'h08);
    cycle(8'h48, 1'b0, 1'b1, 1'b1);
    chk("rr_6", {24'd0, bus.ready_o}, 32'h40);
    cycle(8'h12, 1'b1, 1'b1, 1'b1);
    chk("fix_1", {24'd0, bus.ready_o}, 32'h02);
    cycle(8'h12, 1'b0, 1'b1, 1'b1);
    chk("rr_4", {24'd0, bus.ready_o}, 32'h10);

    // Drain: valid falls, data/grant hold
    cycle(8'h00, 1'b0, 1'b1, 1'b1);
    cycle(8'h00, 1'b0, 1'b1, 1'b1);

    // Reset mid-stall discards the held item
    cycle(8'h08, 1'b0, 1'b1, 1'b1);
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("mid_rst_data", {28'd0, bus.data_o}, 32'd0);
    chk("mid_rst_grant", {29'd0, bus.grant_o}, 32'd0);
    chk("mid_rst_ready", {24'd0, bus.ready_o}, 32'd0);
    exp_q.delete();
    mfull = 0;
    mptr = 0;
    last_data = '0;
    last_grant = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cycle(8'hFF, 1'b0, 1'b1, 1'b1);
    chk("post_rst_ready", {24'd0, bus.ready_o}, 32'h01);

    // Random traffic
    repeat (400) begin
      cycle(M'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
            1'b1);
    end
    repeat (3) cycle(8'h00, 1'b0, 1'b1, 1'b1);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks,
             errors);
    $finish;
  end

endmodule
